// File: rtl/lbp_ring_interp.sv
// LBP ring sampler: passes the four axis samples through and bilinearly interpolates
// the four diagonal samples, either as a 3-stage pipeline or with one time-shared engine.
module lbp_ring_interp #(
    parameter int unsigned R      = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned FRAC_W = 16,
    parameter int unsigned W_A    = 22489,
    parameter int unsigned W_BC   = 15901,
    parameter int unsigned W_D    = 11244,
    parameter int unsigned MODE   = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid_i,
    output logic                           in_ready_o,
    input  logic [4*DATA_W-1:0]            s_axis_i,
    input  logic [16*DATA_W-1:0]           s_diag_i,
    input  logic                           done_i,
    input  logic                           progress_done_i,
    output logic                           out_valid_o,
    input  logic                           out_ready_i,
    output logic [8*(DATA_W+FRAC_W)-1:0]   s_o,
    output logic                           done_o,
    output logic                           progress_done_o
);
    localparam int unsigned OW = DATA_W + FRAC_W;
    localparam int unsigned PW = OW + 1;
    localparam int unsigned SW = OW + 2;
    localparam int unsigned GW = 4 * DATA_W;

    // R==1 puts the sample exactly on corner A: diagonal becomes {A, zeros}.
    function automatic logic [OW-1:0] prod_a(input logic [DATA_W-1:0] a);
        logic [OW-1:0] p;
        if (R == 1) p = {a, {FRAC_W{1'b0}}};
        else        p = OW'(a) * OW'(W_A);
        return p;
    endfunction

    function automatic logic [PW-1:0] prod_bc(input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c);
        logic [PW-1:0] p;
        if (R == 1) p = '0;
        else        p = (PW'(b) + PW'(c)) * PW'(W_BC);
        return p;
    endfunction

    function automatic logic [OW-1:0] prod_d(input logic [DATA_W-1:0] d);
        logic [OW-1:0] p;
        if (R == 1) p = '0;
        else        p = OW'(d) * OW'(W_D);
        return p;
    endfunction

    // Truncating sum; any carry above OW bits clamps to all-ones.
    function automatic logic [OW-1:0] sat_sum(input logic [OW-1:0] pa, input logic [PW-1:0] pbc,
                                              input logic [OW-1:0] pd);
        logic [SW-1:0] s;
        logic [OW-1:0] r;
        s = SW'(pa) + SW'(pbc) + SW'(pd);
        if (|s[SW-1:OW]) r = '1;
        else             r = s[OW-1:0];
        return r;
    endfunction

    function automatic logic [OW-1:0] diag_of(input logic [GW-1:0] g);
        return sat_sum(prod_a(g[0 +: DATA_W]), prod_bc(g[DATA_W +: DATA_W], g[2*DATA_W +: DATA_W]),
                       prod_d(g[3*DATA_W +: DATA_W]));
    endfunction

    // Even slots carry axis samples, odd slots the diagonals.
    function automatic logic [8*OW-1:0] pack_s(input logic [GW-1:0] ax, input logic [OW-1:0] d0,
                                               input logic [OW-1:0] d1, input logic [OW-1:0] d2,
                                               input logic [OW-1:0] d3);
        logic [8*OW-1:0] r;
        for (int j = 0; j < 4; j++) begin
            r[2*j*OW +: OW] = {ax[j*DATA_W +: DATA_W], {FRAC_W{1'b0}}};
        end
        r[1*OW +: OW] = d0;
        r[3*OW +: OW] = d1;
        r[5*OW +: OW] = d2;
        r[7*OW +: OW] = d3;
        return r;
    endfunction

    if (MODE == 0) begin : g_pipe
        logic              en;
        logic              v1_q, v2_q, ov_q;
        logic [GW-1:0]     axis1_q, axis2_q;
        logic [4*GW-1:0]   diag1_q;
        logic              done1_q, prog1_q, done2_q, prog2_q, done_q, prog_q;
        logic [OW-1:0]     pa2_q  [4];
        logic [PW-1:0]     pbc2_q [4];
        logic [OW-1:0]     pd2_q  [4];
        logic [8*OW-1:0]   s_q;

        assign en              = !ov_q || out_ready_i;
        assign in_ready_o      = en && !rst;
        assign out_valid_o     = ov_q;
        assign s_o             = s_q;
        assign done_o          = done_q;
        assign progress_done_o = prog_q;

        // Capture -> multiply -> sum/saturate, all frozen together on back-pressure.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                v1_q    <= 1'b0;
                v2_q    <= 1'b0;
                ov_q    <= 1'b0;
                axis1_q <= '0;
                axis2_q <= '0;
                diag1_q <= '0;
                done1_q <= 1'b0;
                prog1_q <= 1'b0;
                done2_q <= 1'b0;
                prog2_q <= 1'b0;
                done_q  <= 1'b0;
                prog_q  <= 1'b0;
                s_q     <= '0;
                for (int g = 0; g < 4; g++) begin
                    pa2_q[g]  <= '0;
                    pbc2_q[g] <= '0;
                    pd2_q[g]  <= '0;
                end
            end else if (en) begin
                v1_q <= in_valid_i;
                if (in_valid_i) begin
                    axis1_q <= s_axis_i;
                    diag1_q <= s_diag_i;
                    done1_q <= done_i;
                    prog1_q <= progress_done_i;
                end
                v2_q <= v1_q;
                if (v1_q) begin
                    axis2_q <= axis1_q;
                    done2_q <= done1_q;
                    prog2_q <= prog1_q;
                    for (int g = 0; g < 4; g++) begin
                        pa2_q[g]  <= prod_a(diag1_q[g*GW +: DATA_W]);
                        pbc2_q[g] <= prod_bc(diag1_q[g*GW + DATA_W +: DATA_W],
                                             diag1_q[g*GW + 2*DATA_W +: DATA_W]);
                        pd2_q[g]  <= prod_d(diag1_q[g*GW + 3*DATA_W +: DATA_W]);
                    end
                end
                ov_q   <= v2_q;
                done_q <= v2_q && done2_q;
                prog_q <= v2_q && prog2_q;
                if (v2_q) begin
                    s_q <= pack_s(axis2_q, sat_sum(pa2_q[0], pbc2_q[0], pd2_q[0]),
                                  sat_sum(pa2_q[1], pbc2_q[1], pd2_q[1]),
                                  sat_sum(pa2_q[2], pbc2_q[2], pd2_q[2]),
                                  sat_sum(pa2_q[3], pbc2_q[3], pd2_q[3]));
                end
            end
        end
    end else begin : g_serial
        typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;

        state_t          state_q, state_d;
        logic [1:0]      cnt_q, cnt_d;
        logic [GW-1:0]   axis_q;
        logic [4*GW-1:0] dgrp_q;
        logic [GW-1:0]   grp_c;
        logic [OW-1:0]   diag_c;
        logic [OW-1:0]   acc0_q, acc1_q, acc2_q;
        logic            done_cap_q, prog_cap_q, ov_q, done_q, prog_q;
        logic [8*OW-1:0] s_q;

        assign in_ready_o      = (state_q == IDLE) && !rst;
        assign out_valid_o     = ov_q;
        assign s_o             = s_q;
        assign done_o          = done_q;
        assign progress_done_o = prog_q;

        always_comb begin
            grp_c = dgrp_q[0 +: GW];
            case (cnt_q)
                2'd1:    grp_c = dgrp_q[GW +: GW];
                2'd2:    grp_c = dgrp_q[2*GW +: GW];
                2'd3:    grp_c = dgrp_q[3*GW +: GW];
                default: grp_c = dgrp_q[0 +: GW];
            endcase
            diag_c = diag_of(grp_c);
        end

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            case (state_q)
                IDLE: begin
                    if (in_valid_i) begin
                        state_d = CALC;
                        cnt_d   = 2'd0;
                    end
                end
                CALC: begin
                    cnt_d = cnt_q + 2'd1;
                    if (cnt_q == 2'd3) begin
                        state_d = HOLD;
                        cnt_d   = 2'd0;
                    end
                end
                HOLD: begin
                    if (out_ready_i) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= IDLE;
                cnt_q   <= 2'd0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
            end
        end

        // One diagonal per CALC cycle; s_o is only replaced once all four are ready.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                axis_q     <= '0;
                dgrp_q     <= '0;
                acc0_q     <= '0;
                acc1_q     <= '0;
                acc2_q     <= '0;
                done_cap_q <= 1'b0;
                prog_cap_q <= 1'b0;
                ov_q       <= 1'b0;
                done_q     <= 1'b0;
                prog_q     <= 1'b0;
                s_q        <= '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (in_valid_i) begin
                            axis_q     <= s_axis_i;
                            dgrp_q     <= s_diag_i;
                            done_cap_q <= done_i;
                            prog_cap_q <= progress_done_i;
                        end
                    end
                    CALC: begin
                        case (cnt_q)
                            2'd0: acc0_q <= diag_c;
                            2'd1: acc1_q <= diag_c;
                            2'd2: acc2_q <= diag_c;
                            default: begin
                                s_q    <= pack_s(axis_q, acc0_q, acc1_q, acc2_q, diag_c);
                                ov_q   <= 1'b1;
                                done_q <= done_cap_q;
                                prog_q <= prog_cap_q;
                            end
                        endcase
                    end
                    HOLD: begin
                        if (out_ready_i) begin
                            ov_q   <= 1'b0;
                            done_q <= 1'b0;
                            prog_q <= 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_lbp_ring_interp.sv
// Directed bench for lbp_ring_interp: pipeline, serial and saturating-weight instances.
module tb_lbp_ring_interp;
    localparam int OW = 24;

    logic clk = 1'b0;
    logic rst;
    logic [31:0]  axis;
    logic [127:0] diag;
    logic done_i, prog_i;
    logic v0, v1, v2, r0, r1, r2, or0, or1, or2, ov0, ov1, ov2;
    logic d0, d1, d2, p0, p1, p2;
    logic [191:0] s0, s1, s2;
    logic [191:0] held;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    lbp_ring_interp #(.MODE(0)) u0 (
        .clk(clk), .rst(rst), .in_valid_i(v0), .in_ready_o(r0), .s_axis_i(axis), .s_diag_i(diag),
        .done_i(done_i), .progress_done_i(prog_i), .out_valid_o(ov0), .out_ready_i(or0),
        .s_o(s0), .done_o(d0), .progress_done_o(p0));

    lbp_ring_interp #(.MODE(1)) u1 (
        .clk(clk), .rst(rst), .in_valid_i(v1), .in_ready_o(r1), .s_axis_i(axis), .s_diag_i(diag),
        .done_i(done_i), .progress_done_i(prog_i), .out_valid_o(ov1), .out_ready_i(or1),
        .s_o(s1), .done_o(d1), .progress_done_o(p1));

    lbp_ring_interp #(.MODE(0), .W_A(65535), .W_BC(65535), .W_D(65535)) u2 (
        .clk(clk), .rst(rst), .in_valid_i(v2), .in_ready_o(r2), .s_axis_i(axis), .s_diag_i(diag),
        .done_i(done_i), .progress_done_i(prog_i), .out_valid_o(ov2), .out_ready_i(or2),
        .s_o(s2), .done_o(d2), .progress_done_o(p2));

    task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] sl(input logic [191:0] v, input int i);
        return v[i*OW +: OW];
    endfunction

    function automatic logic [127:0] mk_grp(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] c, input logic [7:0] d);
        return {4{d, c, b, a}};
    endfunction

    function automatic logic [23:0] ref_diag(input int a, input int b, input int c, input int d,
                                             input int wa, input int wbc, input int wd);
        longint s;
        s = longint'(wa) * a + longint'(wbc) * (b + c) + longint'(wd) * d;
        if (s > 64'hFFFFFF) return 24'hFFFFFF;
        return 24'(s);
    endfunction

    function automatic logic [191:0] ref_s(input logic [31:0] ax, input logic [127:0] dg,
                                           input int wa, input int wbc, input int wd);
        logic [191:0] r;
        for (int j = 0; j < 4; j++) begin
            r[2*j*OW +: OW]     = {ax[8*j +: 8], 16'h0000};
            r[(2*j+1)*OW +: OW] = ref_diag(int'(dg[32*j +: 8]), int'(dg[32*j+8 +: 8]),
                                           int'(dg[32*j+16 +: 8]), int'(dg[32*j+24 +: 8]),
                                           wa, wbc, wd);
        end
        return r;
    endfunction

    function automatic logic [31:0] ax_k(input int k);
        logic [31:0] r;
        for (int j = 0; j < 4; j++) r[8*j +: 8] = 8'(k*16 + j + 1);
        return r;
    endfunction

    function automatic logic [127:0] dg_k(input int k);
        logic [127:0] r;
        for (int g = 0; g < 4; g++) begin
            r[32*g +: 8]      = 8'(k*20 + g);
            r[32*g + 8 +: 8]  = 8'(k*3 + g);
            r[32*g + 16 +: 8] = 8'(255 - k*7);
            r[32*g + 24 +: 8] = 8'(k + g*50);
        end
        return r;
    endfunction

    initial begin
        int iidx;
        int oidx;
        rst = 1'b1;
        {v0, v1, v2} = 3'b000;
        {or0, or1, or2} = 3'b111;
        axis = '0; diag = '0; done_i = 1'b0; prog_i = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready0", 192'(r0), 192'(0));
        chk("rst_ready1", 192'(r1), 192'(0));
        chk("rst_valid0", 192'(ov0), 192'(0));
        chk("rst_valid1", 192'(ov1), 192'(0));
        chk("rst_s0", s0, '0);
        chk("rst_done0", 192'(d0), 192'(0));
        rst = 1'b0;
        #1;
        chk("post_rst_ready0", 192'(r0), 192'(1));
        chk("post_rst_ready1", 192'(r1), 192'(1));
        chk("post_rst_ready2", 192'(r2), 192'(1));
        tick();

        // MODE0 single beat, all corners 100
        axis = 32'h04030201;
        diag = mk_grp(8'd100, 8'd100, 8'd100, 8'd100);
        v0 = 1'b1;
        tick();
        v0 = 1'b0;
        chk("m0_lat1", 192'(ov0), 192'(0));
        tick();
        chk("m0_lat2", 192'(ov0), 192'(0));
        tick();
        chk("m0_valid", 192'(ov0), 192'(1));
        chk("m0_S1", 192'(sl(s0, 0)), 192'(24'h010000));
        chk("m0_S2", 192'(sl(s0, 1)), 192'(6553500));
        chk("m0_S7", 192'(sl(s0, 6)), 192'(24'h040000));
        chk("m0_S8", 192'(sl(s0, 7)), 192'(6553500));
        chk("m0_done", 192'(d0), 192'(0));
        tick();
        chk("m0_one_cycle", 192'(ov0), 192'(0));
        chk("m0_hold_S2", 192'(sl(s0, 1)), 192'(6553500));

        // MODE0 ten back-to-back beats, downstream stalls cycles 4-6, done on last beat
        iidx = 0;
        oidx = 0;
        for (int c = 0; c < 40 && oidx < 10; c++) begin
            v0 = (iidx < 10);
            axis = ax_k(iidx);
            diag = dg_k(iidx);
            done_i = (iidx == 9);
            or0 = !(c >= 4 && c <= 6);
            #1;
            chk("b2b_ready", 192'(r0), 192'((c >= 4 && c <= 6) ? 0 : 1));
            if (ov0 && or0) begin
                chk("b2b_data", s0, ref_s(ax_k(oidx), dg_k(oidx), 22489, 15901, 11244));
                chk("b2b_done", 192'(d0), 192'(oidx == 9));
                oidx++;
            end
            if (v0 && r0) iidx++;
            tick();
        end
        chk("b2b_count", 192'(oidx), 192'(10));
        v0 = 1'b0;
        or0 = 1'b1;

        // Sideband without a beat is ignored; no duplicated outputs
        done_i = 1'b1;
        prog_i = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("side_valid0", 192'(ov0), 192'(0));
            chk("side_done0", 192'(d0), 192'(0));
            chk("side_done1", 192'(d1), 192'(0));
        end
        done_i = 1'b0;
        prog_i = 1'b0;

        // MODE1 single beat, A=255 only
        axis = 32'hDDCCBBAA;
        diag = mk_grp(8'd255, 8'd0, 8'd0, 8'd0);
        v1 = 1'b1;
        #1;
        chk("m1_ready_idle", 192'(r1), 192'(1));
        tick();
        v1 = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            chk("m1_ready_busy", 192'(r1), 192'(0));
            chk("m1_valid_lat", 192'(ov1), 192'(k == 5));
            if (k < 5) tick();
        end
        chk("m1_S1", 192'(sl(s1, 0)), 192'(24'hAA0000));
        chk("m1_S2", 192'(sl(s1, 1)), 192'(5734695));
        chk("m1_S4", 192'(sl(s1, 3)), 192'(5734695));
        chk("m1_S6", 192'(sl(s1, 5)), 192'(5734695));
        chk("m1_S8", 192'(sl(s1, 7)), 192'(5734695));
        tick();
        chk("m1_valid_drop", 192'(ov1), 192'(0));
        chk("m1_ready_back", 192'(r1), 192'(1));

        // MODE1 with downstream stall in HOLD and progress sideband
        axis = 32'h11223344;
        diag = mk_grp(8'd0, 8'd10, 8'd20, 8'd30);
        prog_i = 1'b1;
        v1 = 1'b1;
        or1 = 1'b0;
        tick();
        v1 = 1'b0;
        prog_i = 1'b0;
        repeat (4) tick();
        chk("m1s_valid", 192'(ov1), 192'(1));
        chk("m1s_data", s1, ref_s(32'h11223344, mk_grp(8'd0, 8'd10, 8'd20, 8'd30), 22489, 15901, 11244));
        chk("m1s_S2", 192'(sl(s1, 1)), 192'(814350));
        chk("m1s_prog", 192'(p1), 192'(1));
        held = s1;
        repeat (2) tick();
        chk("m1s_hold_valid", 192'(ov1), 192'(1));
        chk("m1s_hold_data", s1, held);
        or1 = 1'b1;
        #1;
        chk("m1s_exit_ready", 192'(r1), 192'(0));
        tick();
        chk("m1s_exit_valid", 192'(ov1), 192'(0));
        chk("m1s_exit_prog", 192'(p1), 192'(0));
        chk("m1s_keep_data", s1, held);
        chk("m1s_ready", 192'(r1), 192'(1));

        // Saturation with unit weights, plus the default-weight full-scale case
        axis = 32'h80706050;
        diag = mk_grp(8'd255, 8'd255, 8'd255, 8'd255);
        v0 = 1'b1;
        v2 = 1'b1;
        tick();
        v0 = 1'b0;
        v2 = 1'b0;
        repeat (2) tick();
        chk("sat_valid", 192'(ov2), 192'(1));
        chk("sat_S2", 192'(sl(s2, 1)), 192'(24'hFFFFFF));
        chk("sat_S8", 192'(sl(s2, 7)), 192'(24'hFFFFFF));
        chk("sat_S1", 192'(sl(s2, 0)), 192'(24'h500000));
        chk("full_S4", 192'(sl(s0, 3)), 192'(16711425));
        tick();

        // Reset during MODE1 CALC and MODE0 mid-pipeline discards in-flight beats
        axis = 32'h01010101;
        diag = mk_grp(8'd1, 8'd2, 8'd3, 8'd4);
        v0 = 1'b1;
        v1 = 1'b1;
        tick();
        v0 = 1'b0;
        v1 = 1'b0;
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("mrst_valid1", 192'(ov1), 192'(0));
        chk("mrst_ready1", 192'(r1), 192'(0));
        chk("mrst_s1", s1, '0);
        chk("mrst_s0", s0, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("mrst_idle1", 192'(r1), 192'(1));
        for (int k = 0; k < 8; k++) begin
            tick();
            chk("mrst_stale0", 192'(ov0), 192'(0));
            chk("mrst_stale1", 192'(ov1), 192'(0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/lbp_ring_interp.md
LBP_RING_INTERP -- requirements
Module: lbp_ring_interp

Interface
REQ-001 SHALL have parameter R, default 2: LBP sampling radius, R>=1; R==1 selects bypass, with diagonal output = corner A.
REQ-002 SHALL have parameter DATA_W, default 8: sample width.
REQ-003 SHALL have parameter FRAC_W, default 16: output fraction bits.
REQ-004 SHALL have parameter W_A, default 22489: Q0.FRAC_W weight for corner A.
REQ-005 SHALL have parameter W_BC, default 15901: Q0.FRAC_W weight for each of corners B and C.
REQ-006 SHALL have parameter W_D, default 11244: Q0.FRAC_W weight for corner D.
REQ-007 SHALL have parameter MODE, default 0: 0 = parallel pipeline, 1 = serial single-engine.
REQ-008 SHALL have port clk, input, 1 bit: sole clock, rising edge.
REQ-009 SHALL have port rst, input, 1 bit: reset; one clock, reset asynchronous and active-high.
REQ-010 SHALL have port in_valid_i, input, 1 bit: input beat valid.
REQ-011 SHALL have port in_ready_o, output, 1 bit: block accepts a beat.
REQ-012 SHALL have port s_axis_i, input, 4*DATA_W bits: samples at 0/90/180/270 deg, 0 deg in LSBs.
REQ-013 SHALL have port s_diag_i, input, 16*DATA_W bits: 45/135/225/315 deg groups, 45 deg in LSBs; each group is {D,C,B,A}, A in LSBs.
REQ-014 SHALL have port done_i, input, 1 bit: frame-done sideband.
REQ-015 SHALL have port progress_done_i, input, 1 bit: progress sideband.
REQ-016 SHALL have port out_valid_o, output, 1 bit: result valid.
REQ-017 SHALL have port out_ready_i, input, 1 bit: downstream accepts.
REQ-018 SHALL have port s_o, output, 8*(DATA_W+FRAC_W) bits: S1..S8 for 0,45,...,315 deg, S1 in LSBs.
REQ-019 SHALL have port done_o, output, 1 bit: done_i of the emitted beat.
REQ-020 SHALL have port progress_done_o, output, 1 bit: progress_done_i of the emitted beat.

Function
REQ-021 SHALL accept a beat only on a rising edge where in_valid_i && in_ready_o; it SHALL capture samples, done_i and progress_done_i together.
REQ-022 SHALL output each axis sample as {sample, FRAC_W zeros}, unweighted.
REQ-023 SHALL compute each diagonal as sum = W_A*A + W_BC*(B+C) + W_D*D at full width DATA_W+FRAC_W+2.
REQ-024 SHALL saturate the diagonal sum to all-ones of DATA_W+FRAC_W on overflow and SHALL NOT round.
REQ-025 MODE 0 SHALL run a 3-stage pipeline: capture, multiply, sum/saturate; out_valid_o SHALL rise 3 cycles after acceptance when out_ready_i stays high.
REQ-026 MODE 0 SHALL use a global enable en = !out_valid_o || out_ready_i; in_ready_o = en; all stages SHALL hold while en==0.
REQ-027 MODE 0 SHALL sustain 1 beat/cycle when out_ready_i==1.
REQ-028 MODE 1 SHALL use an FSM with states IDLE, CALC and HOLD and one multiplier set time-shared over the 4 diagonals.
REQ-029 MODE 1, IDLE: in_ready_o=1; on acceptance SHALL go to CALC with channel counter = 0.
REQ-030 MODE 1, CALC: in_ready_o=0; SHALL compute diagonal[counter] per cycle; at counter==3 SHALL go to HOLD and set out_valid_o.
REQ-031 MODE 1: out_valid_o SHALL rise 5 cycles after the acceptance edge.
REQ-032 MODE 1, HOLD: s_o/done_o/progress_done_o SHALL stay stable; on out_valid_o && out_ready_i SHALL go to IDLE and clear out_valid_o.
REQ-033 MODE 1: a new beat SHALL NOT be accepted in the cycle HOLD exits.
REQ-034 R==1 SHALL keep the latency and handshake timing of the selected MODE.
REQ-035 done_o/progress_done_o SHALL be meaningful only while out_valid_o==1 and SHALL be 0 otherwise.
REQ-036 s_o SHALL hold its last value while out_valid_o==0.
REQ-037 Sideband asserted without an accepted beat SHALL be ignored.

Reset
REQ-038 While rst=1, all registers SHALL clear asynchronously: out_valid_o=0, s_o=0, done_o=0, progress_done_o=0, FSM=IDLE, counter=0.
REQ-039 While rst=1, in_ready_o SHALL be 0; it SHALL be 1 in the first cycle after rst deasserts.
REQ-040 Reset mid-pipeline or mid-CALC SHALL discard in-flight beats; no out_valid_o SHALL follow for them.

Verification
REQ-041 SHALL cover: MODE0, R=2, diag A=B=C=D=100, out_ready_i=1 -> 3 cycles later S2 = 100*65535 = 6553500, S1 = {axis0, 16'h0}, out_valid_o=1 for one cycle.
REQ-042 SHALL cover: MODE0, 10 back-to-back beats, out_ready_i low on cycles 4-6 -> no loss or duplication, order kept, in_ready_o=0 exactly while stalled.
REQ-043 SHALL cover: MODE1, one beat with A=255, B=C=D=0 -> out_valid_o at acceptance+5, S2..S8 = 255*22489 = 5734695, in_ready_o=0 for cycles +1..+5.
REQ-044 SHALL cover: W_A=W_BC=W_D=65535, all corners 255 -> diagonals saturate to 24'hFFFFFF.
REQ-045 SHALL cover: done_i=1 on the last beat only -> done_o=1 only on the matching output; done_i pulse with in_valid_i=0 -> done_o never 1.
REQ-046 SHALL cover: rst pulse during MODE1 CALC -> out_valid_o=0 immediately, IDLE, no stale output after release.
